// File: rtl/packet_mux.sv
// ---------------------------------------------------------------------------
// packet_mux
// Transmit-side packet framer. On an accepted start it makes a pre-pass over
// the payload buffer to compute the frame checksum, then sends
//   checksum | address | count | N data bytes
// one byte at a time through a UART transmitter handshake. The checksum makes
// the 8-bit sum of every byte in the frame equal to 0x00.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start         request one packet (sampled only while idle)
//   addr_in       packet address field, latched on accepted start
//   count_in      payload length N (0 means 256), latched on accepted start
//   rd_addr       payload buffer read address (registered)
//   rd_data       payload buffer data, valid the cycle after rd_addr changes
//   tx_start      one-cycle pulse: UART should send tx_data
//   tx_data       byte to send, stable from tx_start until tx_done_tick
//   tx_done_tick  UART finished the current byte
//   busy          high from accepted start until done_tick inclusive
//   done_tick     one-cycle pulse after the last data byte completes
//   current_state state register, for debug
// ---------------------------------------------------------------------------
module packet_mux (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr_in,
    input  logic [7:0] count_in,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done_tick,
    output logic       busy,
    output logic       done_tick,
    output logic [3:0] current_state
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SUM    = 4'd1,
        ST_CHK    = 4'd2,
        ST_CHKW   = 4'd3,
        ST_ADR    = 4'd4,
        ST_ADRW   = 4'd5,
        ST_CNT    = 4'd6,
        ST_CNTW   = 4'd7,
        ST_DFETCH = 4'd8,
        ST_DSEND  = 4'd9,
        ST_DWAIT  = 4'd10,
        ST_DONE   = 4'd11
    } state_t;

    state_t     state_r;
    logic [7:0] addr_r;
    logic [7:0] count_r;
    logic [7:0] sum_r;
    logic [8:0] idx_r;
    logic [7:0] rd_addr_r;
    logic [7:0] tx_data_r;
    logic       tx_start_r;
    logic       busy_r;
    logic       done_tick_r;

    logic [8:0] len_s;
    logic       byte_done_s;

    // Two's-complement negation that closes the frame sum to 0x00.
    function automatic logic [7:0] frame_checksum(input logic [7:0] partial_sum);
        frame_checksum = 8'h00 - partial_sum;
    endfunction

    // Effective payload length: a count byte of zero encodes 256 bytes.
    assign len_s = (count_r == 8'h00) ? 9'd256 : {1'b0, count_r};

    // A done tick coinciding with our own tx_start belongs to an earlier byte
    // and must not complete the byte we are just handing over.
    assign byte_done_s = tx_done_tick & ~tx_start_r;

    assign rd_addr       = rd_addr_r;
    assign tx_data       = tx_data_r;
    assign tx_start      = tx_start_r;
    assign busy          = busy_r;
    assign done_tick     = done_tick_r;
    assign current_state = state_r;

    // Framer state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= 8'h00;
            count_r     <= 8'h00;
            sum_r       <= 8'h00;
            idx_r       <= 9'd0;
            rd_addr_r   <= 8'h00;
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_tick_r <= 1'b0;
        end else begin
            tx_start_r  <= 1'b0;
            done_tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_r    <= addr_in;
                        count_r   <= count_in;
                        sum_r     <= addr_in + count_in;
                        idx_r     <= 9'd0;
                        rd_addr_r <= 8'h00;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SUM;
                    end
                end
                // Pre-pass: idx_r counts cycles j = 0..L. rd_addr leads the
                // data by one cycle, so byte j-1 is added in cycle j.
                ST_SUM: begin
                    if (idx_r != 9'd0) begin
                        sum_r <= sum_r + rd_data;
                    end
                    if ((idx_r + 9'd1) < len_s) begin
                        rd_addr_r <= idx_r[7:0] + 8'd1;
                    end
                    if (idx_r == len_s) begin
                        idx_r   <= 9'd0;
                        state_r <= ST_CHK;
                    end else begin
                        idx_r <= idx_r + 9'd1;
                    end
                end
                ST_CHK: begin
                    tx_data_r  <= frame_checksum(sum_r);
                    tx_start_r <= 1'b1;
                    state_r    <= ST_CHKW;
                end
                ST_CHKW: begin
                    if (byte_done_s) begin
                        state_r <= ST_ADR;
                    end
                end
                ST_ADR: begin
                    tx_data_r  <= addr_r;
                    tx_start_r <= 1'b1;
                    state_r    <= ST_ADRW;
                end
                ST_ADRW: begin
                    if (byte_done_s) begin
                        state_r <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    tx_data_r  <= count_r;
                    tx_start_r <= 1'b1;
                    state_r    <= ST_CNTW;
                end
                // The read address for the next data byte is issued on the
                // way into DFETCH so the synchronous RAM output is already
                // valid when DSEND captures it.
                ST_CNTW: begin
                    if (byte_done_s) begin
                        idx_r     <= 9'd0;
                        rd_addr_r <= 8'h00;
                        state_r   <= ST_DFETCH;
                    end
                end
                ST_DFETCH: begin
                    rd_addr_r <= idx_r[7:0];
                    state_r   <= ST_DSEND;
                end
                ST_DSEND: begin
                    tx_data_r  <= rd_data;
                    tx_start_r <= 1'b1;
                    state_r    <= ST_DWAIT;
                end
                ST_DWAIT: begin
                    if (byte_done_s) begin
                        idx_r <= idx_r + 9'd1;
                        if ((idx_r + 9'd1) == len_s) begin
                            done_tick_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            rd_addr_r <= idx_r[7:0] + 8'd1;
                            state_r   <= ST_DFETCH;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_mux.sv
// ---------------------------------------------------------------------------
// tb_packet_mux
// Self-checking bench for packet_mux. A synchronous payload RAM and a UART
// responder surround the DUT; expected frames come from plain arithmetic on
// the payload contents.
// ---------------------------------------------------------------------------
module tb_packet_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] addr_in;
    logic [7:0] count_in;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_tick;
    logic       busy;
    logic       done_tick;
    logic [3:0] current_state;

    packet_mux dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .addr_in      (addr_in),
        .count_in     (count_in),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .done_tick    (done_tick),
        .current_state(current_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous payload RAM.
    logic [7:0] mem [256];
    always @(posedge clk) rd_data <= mem[rd_addr];

    // UART responder / monitor state.
    int         uart_delay   = 10;
    bit         pending      = 1'b0;
    int         remain       = 0;
    logic [7:0] held         = 8'h00;
    logic [7:0] got_q [$];
    int         first_cap_cyc = 0;
    int         stab_err     = 0;
    int         extra_start  = 0;
    int         done_cnt     = 0;
    int         rd_steps     = 0;
    logic [7:0] prev_rd      = 8'h00;
    bit         inject_fetch = 1'b0;
    int         inject_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART responder: captures each tx_start byte, answers with tx_done_tick
    // uart_delay cycles later, and watches data stability and stray pulses.
    initial begin
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (tx_data !== held) stab_err++;
                    if (tx_start !== 1'b0) extra_start++;
                    remain--;
                    if (remain <= 0) begin
                        tx_done_tick = 1'b1;
                        pending      = 1'b0;
                    end
                end else if (tx_start === 1'b1) begin
                    if (got_q.size() == 0) first_cap_cyc = cyc;
                    got_q.push_back(tx_data);
                    held    = tx_data;
                    remain  = uart_delay;
                    pending = 1'b1;
                end else if (inject_fetch && current_state == 4'd8) begin
                    tx_done_tick = 1'b1;
                    inject_cnt++;
                end
                if (done_tick === 1'b1) done_cnt++;
                if (busy === 1'b1 && {1'b0, rd_addr} == {1'b0, prev_rd} + 9'd1) rd_steps++;
                prev_rd = rd_addr;
            end
        end
    end

    task automatic clear_monitors();
        got_q       = {};
        stab_err    = 0;
        extra_start = 0;
        done_cnt    = 0;
        rd_steps    = 0;
        inject_cnt  = 0;
    endtask

    // Send one packet using mem[0..L-1] and compare against the reference frame.
    task automatic run_packet(input logic [7:0] a, input logic [7:0] c, input int dly,
                              input bit start_in_dwait);
        int         len;
        int         sum;
        int         tmo;
        int         t;
        int         c0;
        int         fsum;
        logic [7:0] ck;
        logic [7:0] exp_q [$];
        len = (c == 8'h00) ? 256 : int'(c);
        sum = int'(a) + int'(c);
        for (int i = 0; i < len; i++) sum += int'(mem[i]);
        ck = 8'(256 - (sum % 256));
        exp_q = {};
        exp_q.push_back(ck);
        exp_q.push_back(a);
        exp_q.push_back(c);
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        tmo = 200 + (len + 3) * (dly + 6) + 2 * len;
        uart_delay = dly;
        clear_monitors();

        @(negedge clk);
        addr_in  = a;
        count_in = c;
        start    = 1'b1;
        @(negedge clk);
        c0       = cyc;
        start    = 1'b0;
        addr_in  = 8'($urandom);
        count_in = 8'($urandom);
        check_eq("busy_on", busy, 1);

        t = 0;
        if (start_in_dwait) begin
            while (!(current_state == 4'd10 && got_q.size() >= 4) && t < tmo) begin
                @(negedge clk);
                t++;
            end
            start    = 1'b1;
            addr_in  = a ^ 8'h5A;
            count_in = 8'd9;
            @(negedge clk);
            start = 1'b0;
        end
        while (done_cnt == 0 && t < tmo) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", done_cnt, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_off", busy, 0);
        check_eq("done_once", done_cnt, 1);
        check_eq("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq("byte", got_q[i], exp_q[i]);
        end
        fsum = 0;
        foreach (got_q[i]) fsum += int'(got_q[i]);
        check_eq("frame_sum", fsum % 256, 0);
        check_eq("first_lat", first_cap_cyc - c0, len + 2);
        check_eq("tx_stable", stab_err, 0);
        check_eq("extra_start", extra_start, 0);
        check_eq("rd_walk", rd_steps, 2 * (len - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_tx_data"}, tx_data, 8'h00);
        check_eq({tag, "_rd_addr"}, rd_addr, 8'h00);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done_tick, 0);
        check_eq({tag, "_state"}, current_state, 4'd0);
    endtask

    initial begin
        int t;
        int ln;
        reset    = 1'b1;
        start    = 1'b0;
        addr_in  = 8'h00;
        count_in = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single-byte payload.
        mem[0] = 8'h05;
        run_packet(8'h10, 8'd1, 10, 1'b0);
        check_eq("t1_chk", got_q[0], 8'hEA);

        // Three-byte payload.
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        run_packet(8'h20, 8'd3, 10, 1'b0);
        check_eq("t2_chk", got_q[0], 8'hD7);

        // Count 0 means 256 bytes.
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        run_packet(8'h00, 8'h00, 3, 1'b0);

        // Start during DWAIT and done ticks during DFETCH are both ignored.
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        inject_fetch = 1'b1;
        run_packet(8'h3C, 8'd4, 6, 1'b1);
        inject_fetch = 1'b0;
        check_eq("inject_seen", inject_cnt > 0, 1);

        // Reset during DWAIT of the second data byte.
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        clear_monitors();
        uart_delay = 20;
        @(negedge clk);
        addr_in  = 8'h77;
        count_in = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(current_state == 4'd10 && got_q.size() == 5) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("reach_dwait2", t < 2000, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_packet(8'h77, 8'd4, 5, 1'b0);

        // Very slow UART.
        mem[0] = 8'($urandom);
        run_packet(8'hA5, 8'd1, 1000, 1'b0);

        // Randomized packets.
        for (int k = 0; k < 6; k++) begin
            ln = int'($urandom_range(1, 24));
            for (int i = 0; i < ln; i++) mem[i] = 8'($urandom);
            run_packet(8'($urandom), 8'(ln), int'($urandom_range(1, 8)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_mux.md
# packet_mux

Transmit-side packet framer: on a start request it reads a payload from a synchronous byte buffer and emits one framed packet as a byte stream through a UART transmitter handshake. Frame: 1 byte checksum | 1 byte address | 1 byte count | N data bytes. The checksum is chosen so that the 8-bit sum of all bytes in the frame is 0x00. The block sits between a payload RAM and the UART TX and is the PC-bound counterpart of the host-to-FPGA packet receiver.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request one packet; sampled only in IDLE
- addr_in  in  8  packet address field; latched on accepted start
- count_in  in  8  payload length N; 0 means 256; latched on accepted start
- rd_addr  out  8  payload buffer read address (registered)
- rd_data  in  8  buffer data, valid the cycle after rd_addr changes (sync RAM)
- tx_start  out  1  one-cycle pulse: UART should send tx_data
- tx_data  out  8  byte to send; held stable from tx_start until tx_done_tick
- tx_done_tick  in  1  UART finished current byte
- busy  out  1  high from accepted start until done_tick inclusive
- done_tick  out  1  one-cycle pulse after last data byte's tx_done_tick
- current_state  out  4  state register, for debug

## Operation
- States: IDLE(0), SUM(1), CHK(2), CHKW(3), ADR(4), ADRW(5), CNT(6), CNTW(7), DFETCH(8), DSEND(9), DWAIT(10), DONE(11). Undefined encodings -> IDLE.
- L = (count==0) ? 256 : count; byte index idx is 9 bits.
- IDLE: start=1 -> latch addr/count, sum <= addr_in + count_in (mod 256), idx <= 0, rd_addr <= 0, -> SUM.
- SUM (pre-pass): cycle j=0..L; for j<L rd_addr=j; for j>=1 sum += rd_data (byte j-1). After adding byte L-1 -> CHK. Lasts L+1 cycles.
- CHK: tx_data <= (0 - sum) mod 256, tx_start=1 for one cycle -> CHKW. CHKW: wait for tx_done_tick -> ADR.
- ADR/ADRW: same with latched address. CNT/CNTW: same with latched count byte (0x00 when N=256).
- DFETCH: rd_addr <= idx[7:0] -> DSEND. DSEND: tx_data <= rd_data, tx_start=1 -> DWAIT.
- DWAIT: on tx_done_tick: idx += 1; if idx+1 == L -> DONE else -> DFETCH.
- DONE: done_tick=1 one cycle -> IDLE.
- All arithmetic 8-bit, wrap mod 256.
- start while not IDLE ignored; no queueing. start held high in IDLE after DONE starts a new packet.
- Payload buffer must not change between accepted start and done_tick (system-level rule).

## Timing
- Reset (async): state IDLE; tx_start 0, tx_data 0x00, rd_addr 0x00, busy 0, done_tick 0, sum/idx 0. Reset mid-packet aborts immediately; no further tx_start; any byte already in the UART is not recalled.
- Start accepted at edge E0; first tx_start (checksum) asserted in cycle E0+L+2.
- Per header byte: tx_start one cycle after entering send state; next byte's tx_start no earlier than 1 cycle after tx_done_tick. Per data byte: 2 cycles (DFETCH, DSEND) after tx_done_tick of previous byte.
- tx_done_tick is only sampled in CHKW/ADRW/CNTW/DWAIT; ignored elsewhere, including same cycle as tx_start.
- done_tick asserted 1 cycle after the last data byte's tx_done_tick; busy drops the cycle after done_tick.
- Exactly L+3 tx_start pulses per packet.

## Test plan
- addr 0x10, count 1, data {0x05}, tx_done_tick 10 cycles after each tx_start -> bytes EA 10 01 05, one done_tick, busy low after.
- addr 0x20, count 3, data {01,02,03} -> bytes D7 20 03 01 02 03; sum of frame = 0x00; first tx_start exactly 5 cycles after start edge.
- addr 0x00, count 0, 256 bytes of 0x01 -> 259 bytes: 00 00 00 then 256x 01; rd_addr walks 0x00..0xFF twice (pre-pass, data).
- start pulsed during DWAIT of a 4-byte packet -> ignored; exactly 7 tx_start pulses; tx_done_tick pulsed while in DFETCH -> ignored, no skipped byte.
- reset asserted during DWAIT of byte 2 -> all outputs at reset values same cycle; subsequent start sends a complete correct frame.
- tx_done_tick delayed 1000 cycles -> tx_data stable throughout, no extra tx_start.
